// File: rtl/glyph_scan_pkg.sv
// rtl/glyph_scan_pkg.sv - shared FSM state encoding and width helpers for glyph_margin_scan
package glyph_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } scan_state_e;

    function automatic int col_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int row_width(input int h);
        return $clog2(h + 1);
    endfunction

    function automatic int idx_width(input int h);
        return (h > 1) ? $clog2(h) : 1;
    endfunction

endpackage

// File: rtl/lead_zero_cnt.sv
// rtl/lead_zero_cnt.sv - combinational leading-zero count, returns N for an all-zero input
module lead_zero_cnt #(
    parameter int N = 8
) (
    input  logic [N-1:0]             din,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int CW = $clog2(N + 1);

    // Scanning upward lets the highest set bit win the last assignment.
    always_comb begin
        count = CW'(N);
        for (int i = 0; i < N; i++) begin
            if (din[i]) count = CW'(N - 1 - i);
        end
    end

endmodule

// File: rtl/glyph_margin_scan.sv
// rtl/glyph_margin_scan.sv - measures empty left/right/top/bottom margins of a latched glyph bitmap
module glyph_margin_scan
    import glyph_scan_pkg::*;
#(
    parameter int W   = 24,
    parameter int H   = 64,
    parameter int RPC = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [W*H-1:0]            bitmap,
    output logic                      busy,
    output logic                      done,
    output logic [col_width(W)-1:0]   left,
    output logic [col_width(W)-1:0]   right,
    output logic [row_width(H)-1:0]   top,
    output logic [row_width(H)-1:0]   bottom,
    output logic                      empty
);

    localparam int CW = col_width(W);
    localparam int RW = row_width(H);
    localparam int IW = idx_width(H);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] SCAN = ST_SCAN;
    localparam logic [1:0] FIN  = ST_FIN;

    if (H % RPC != 0) begin : g_rpc_check
        $error("glyph_margin_scan: H must be a multiple of RPC");
    end

    logic [1:0]      state_q;
    logic [W*H-1:0]  bm_q;
    logic [W-1:0]    mask_q;
    logic [W-1:0]    mask_rev;
    logic [IW-1:0]   first_row_q;
    logic [IW-1:0]   last_row_q;
    logic            found_q;
    logic [RW-1:0]   ptr_q;

    logic [W-1:0]    grp_mask;
    logic [RPC-1:0]  row_or;
    logic            grp_any;
    logic [IW-1:0]   grp_first;
    logic [IW-1:0]   grp_last;
    logic [CW-1:0]   lz_left;
    logic [CW-1:0]   lz_right;

    // The latched copy shifts up each scan cycle, so the current group is always the top RPC rows.
    always_comb begin
        grp_mask  = '0;
        row_or    = '0;
        grp_first = '0;
        grp_last  = '0;
        for (int r = 0; r < RPC; r++) begin
            row_or[r] = |bm_q[W*H-1 - r*W -: W];
            grp_mask  = grp_mask | bm_q[W*H-1 - r*W -: W];
        end
        for (int r = RPC - 1; r >= 0; r--) begin
            if (row_or[r]) grp_first = IW'(r);
        end
        for (int r = 0; r < RPC; r++) begin
            if (row_or[r]) grp_last = IW'(r);
        end
        grp_any = |row_or;
    end

    always_comb begin
        mask_rev = '0;
        for (int i = 0; i < W; i++) mask_rev[i] = mask_q[W-1-i];
    end

    lead_zero_cnt #(.N(W)) u_lead (
        .din   (mask_q),
        .count (lz_left)
    );

    lead_zero_cnt #(.N(W)) u_trail (
        .din   (mask_rev),
        .count (lz_right)
    );

    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: begin
                if (start) begin
                    bm_q        <= bitmap;
                    mask_q      <= '0;
                    found_q     <= 1'b0;
                    first_row_q <= '0;
                    last_row_q  <= '0;
                    ptr_q       <= '0;
                end
            end
            SCAN: begin
                bm_q   <= bm_q << (RPC * W);
                mask_q <= mask_q | grp_mask;
                ptr_q  <= ptr_q + RW'(RPC);
                if (grp_any) begin
                    if (!found_q) first_row_q <= ptr_q[IW-1:0] + grp_first;
                    found_q    <= 1'b1;
                    last_row_q <= ptr_q[IW-1:0] + grp_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            empty   <= 1'b0;
            left    <= '0;
            right   <= '0;
            top     <= '0;
            bottom  <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (ptr_q == RW'(H - RPC)) state_q <= FIN;
                end
                FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                    empty   <= (mask_q == '0);
                    if (mask_q == '0) begin
                        left   <= CW'(W);
                        right  <= CW'(W);
                        top    <= RW'(H);
                        bottom <= RW'(H);
                    end else begin
                        left   <= lz_left;
                        right  <= lz_right;
                        top    <= RW'(first_row_q);
                        bottom <= RW'(H - 1) - RW'(last_row_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_margin_scan.sv
// tb/tb_glyph_margin_scan.sv - directed self-checking bench for glyph_margin_scan (RPC=1 and RPC=4)
module tb_glyph_margin_scan;

    localparam int W = 24;
    localparam int H = 64;

    logic           clk;
    logic           rst;
    logic           start_a, start_b;
    logic [W*H-1:0] bitmap_a, bitmap_b;
    logic           busy_a, done_a, empty_a, busy_b, done_b, empty_b;
    logic [4:0]     left_a, right_a, left_b, right_b;
    logic [6:0]     top_a, bottom_a, top_b, bottom_b;

    int checks = 0;
    int errors = 0;

    glyph_margin_scan #(.W(W), .H(H), .RPC(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bitmap(bitmap_a),
        .busy(busy_a), .done(done_a), .left(left_a), .right(right_a),
        .top(top_a), .bottom(bottom_a), .empty(empty_a)
    );

    glyph_margin_scan #(.W(W), .H(H), .RPC(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bitmap(bitmap_b),
        .busy(busy_b), .done(done_b), .left(left_b), .right(right_b),
        .top(top_b), .bottom(bottom_b), .empty(empty_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W*H-1:0] pattern1();
        logic [W*H-1:0] bm;
        bm = '0;
        for (int r = 0; r < H; r++) begin
            if (r == 0 || r == 5 || r == 6 || r == 62 || r == 63) bm[W*H-1 - r*W -: W] = 24'h000000;
            else if (r == 1 || r == 2) bm[W*H-1 - r*W -: W] = 24'h0000ff;
            else bm[W*H-1 - r*W -: W] = 24'h3fffff;
        end
        return bm;
    endfunction

    function automatic logic [W*H-1:0] single_pixel();
        logic [W*H-1:0] bm;
        bm = '0;
        bm[W*H-1 - 10*W - 5] = 1'b1;
        return bm;
    endfunction

    // Launches one run; lat = cycles from the start edge to done, -1 on timeout.
    task automatic run_glyph(input logic [W*H-1:0] bm, input bit use_b, output int lat);
        @(negedge clk);
        if (use_b) begin bitmap_b = bm; start_b = 1'b1; end
        else begin bitmap_a = bm; start_a = 1'b1; end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        bitmap_a = '0; bitmap_b = '0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if ((use_b ? done_b : done_a) === 1'b1) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bitmap_a = '0; bitmap_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, empty_a, left_a, right_a, top_a, bottom_a} !== '0) begin
            errors++; $display("FAIL reset_a: outputs=%h required 0", {busy_a, done_a, empty_a, left_a, right_a, top_a, bottom_a});
        end
        checks++;
        if ({busy_b, done_b, empty_b, left_b, right_b, top_b, bottom_b} !== '0) begin
            errors++; $display("FAIL reset_b: outputs=%h required 0", {busy_b, done_b, empty_b, left_b, right_b, top_b, bottom_b});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_pattern();
        int lat;
        run_glyph(pattern1(), 1'b0, lat);
        checks++;
        if (lat !== 65) begin errors++; $display("FAIL pattern_latency: got %0d required 65", lat); end
        checks++;
        if ({left_a, right_a, top_a, bottom_a, empty_a} !== {5'd2, 5'd0, 7'd1, 7'd2, 1'b0}) begin
            errors++; $display("FAIL pattern_margins: l=%0d r=%0d t=%0d b=%0d e=%0d required 2 0 1 2 0", left_a, right_a, top_a, bottom_a, empty_a);
        end
        checks++;
        if (busy_a !== 1'b0) begin errors++; $display("FAIL pattern_busy_fall: got %0b required 0", busy_a); end
        @(posedge clk); #1;
        checks++;
        if (done_a !== 1'b0 || left_a !== 5'd2) begin
            errors++; $display("FAIL pattern_done_pulse_hold: done=%0b left=%0d required 0 2", done_a, left_a);
        end
    endtask

    task automatic test_empty();
        int lat;
        run_glyph('0, 1'b0, lat);
        checks++;
        if (lat !== 65 || {left_a, right_a, top_a, bottom_a, empty_a} !== {5'd24, 5'd24, 7'd64, 7'd64, 1'b1}) begin
            errors++; $display("FAIL empty_bitmap: lat=%0d l=%0d r=%0d t=%0d b=%0d e=%0d required 65 24 24 64 64 1", lat, left_a, right_a, top_a, bottom_a, empty_a);
        end
    endtask

    task automatic test_single_pixel();
        int lat;
        run_glyph(single_pixel(), 1'b0, lat);
        checks++;
        if (lat !== 65 || {left_a, right_a, top_a, bottom_a, empty_a} !== {5'd5, 5'd18, 7'd10, 7'd53, 1'b0}) begin
            errors++; $display("FAIL single_pixel: lat=%0d l=%0d r=%0d t=%0d b=%0d e=%0d required 65 5 18 10 53 0", lat, left_a, right_a, top_a, bottom_a, empty_a);
        end
    endtask

    task automatic test_all_ones();
        int lat;
        run_glyph('1, 1'b0, lat);
        checks++;
        if (lat !== 65 || {left_a, right_a, top_a, bottom_a, empty_a} !== '0) begin
            errors++; $display("FAIL all_ones: lat=%0d l=%0d r=%0d t=%0d b=%0d e=%0d required 65 0 0 0 0 0", lat, left_a, right_a, top_a, bottom_a, empty_a);
        end
    endtask

    task automatic test_rpc4();
        int lat;
        run_glyph(pattern1(), 1'b1, lat);
        checks++;
        if (lat !== 17) begin errors++; $display("FAIL rpc4_latency: got %0d required 17", lat); end
        checks++;
        if ({left_b, right_b, top_b, bottom_b, empty_b} !== {5'd2, 5'd0, 7'd1, 7'd2, 1'b0}) begin
            errors++; $display("FAIL rpc4_margins: l=%0d r=%0d t=%0d b=%0d e=%0d required 2 0 1 2 0", left_b, right_b, top_b, bottom_b, empty_b);
        end
        run_glyph(single_pixel(), 1'b1, lat);
        checks++;
        if (lat !== 17 || {left_b, right_b, top_b, bottom_b} !== {5'd5, 5'd18, 7'd10, 7'd53}) begin
            errors++; $display("FAIL rpc4_single: lat=%0d l=%0d r=%0d t=%0d b=%0d required 17 5 18 10 53", lat, left_b, right_b, top_b, bottom_b);
        end
    endtask

    task automatic test_start_mid_scan();
        int lat;
        int extra;
        @(negedge clk); bitmap_a = pattern1(); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0; bitmap_a = '1;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            if (i == 10) start_a = 1'b1;
            if (i == 11) start_a = 1'b0;
            @(posedge clk); #1;
            if (i == 10) begin
                checks++;
                if (busy_a !== 1'b1) begin errors++; $display("FAIL midstart_busy: got %0b required 1", busy_a); end
            end
            if (done_a === 1'b1) begin lat = i; break; end
        end
        checks++;
        if (lat !== 65 || left_a !== 5'd2 || top_a !== 7'd1) begin
            errors++; $display("FAIL midstart_done: lat=%0d l=%0d t=%0d required 65 2 1", lat, left_a, top_a);
        end
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL midstart_extra_done: got %0d required 0", extra); end
    endtask

    task automatic test_rst_mid_scan();
        int extra;
        @(negedge clk); bitmap_a = single_pixel(); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        checks++;
        if ({busy_a, done_a, empty_a, left_a, right_a, top_a, bottom_a} !== '0) begin
            errors++; $display("FAIL rst_midscan_outputs: outputs=%h required 0", {busy_a, done_a, empty_a, left_a, right_a, top_a, bottom_a});
        end
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done_a === 1'b1 || busy_a === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL rst_midscan_no_done: activity cycles=%0d required 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_glyph(pattern1(), 1'b0, lat);
        checks++;
        if (lat !== 65) begin errors++; $display("FAIL b2b_first_latency: got %0d required 65", lat); end
        // Still inside the done cycle: the controller is IDLE, so this start is accepted.
        bitmap_a = single_pixel(); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0; bitmap_a = '0;
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %0b required 1", busy_a); end
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) begin lat = i; break; end
        end
        checks++;
        if (lat !== 65 || {left_a, right_a, top_a, bottom_a} !== {5'd5, 5'd18, 7'd10, 7'd53}) begin
            errors++; $display("FAIL b2b_second: lat=%0d l=%0d r=%0d t=%0d b=%0d required 65 5 18 10 53", lat, left_a, right_a, top_a, bottom_a);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_empty();
        test_single_pixel();
        test_all_ones();
        test_rpc4();
        test_start_mid_scan();
        test_rst_mid_scan();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
